// File: rtl/state_code_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : state_code_monitor                                            |
// | Purpose  : Passive checker on the 8-bit control-FSM state code bus.      |
// |            Decodes each sampled code, checks every step against the      |
// |            legal transition set, counts violations in a saturating       |
// |            counter and raises a sticky alarm at ALARM_THRESH.            |
// | Config   : `define STATE_MON_STALL_EN makes a repeated code in TRACK a    |
// |            legal stall instead of a violation.                           |
// | Ports    : clk, rst_n (async, active-low)                                 |
// |            code_in[7:0], code_valid, clr_alarm                            |
// |            decoded_state[3:0], state_valid, synced, violation            |
// |            viol_prev[7:0], viol_cur[7:0], err_count[CNT_W-1:0], alarm    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module state_code_monitor #(
  parameter int ALARM_THRESH = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       code_in,
  input  logic             code_valid,
  input  logic             clr_alarm,
  output logic [3:0]       decoded_state,
  output logic             state_valid,
  output logic             synced,
  output logic             violation,
  output logic [7:0]       viol_prev,
  output logic [7:0]       viol_cur,
  output logic [CNT_W-1:0] err_count,
  output logic             alarm
);

  typedef enum logic [0:0] {
    S_UNSYNC = 1'b0,
    S_TRACK  = 1'b1
  } state_t;

  localparam logic [7:0] c_SYNC_CODE = 8'h55;

  // Code is one of the six encodings the FSM can legally present.
  function automatic logic code_known(input logic [7:0] c);
    case (c)
      8'h55, 8'hAA, 8'hF0, 8'h0F, 8'hFF, 8'h00: code_known = 1'b1;
      default:                                  code_known = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] code_index(input logic [7:0] c);
    case (c)
      8'h55:   code_index = 4'h0;
      8'hAA:   code_index = 4'h1;
      8'hF0:   code_index = 4'h3;
      8'h0F:   code_index = 4'hA;
      8'hFF:   code_index = 4'hF;
      8'h00:   code_index = 4'h5;
      default: code_index = 4'h0;
    endcase
  endfunction

  function automatic logic step_legal(input logic [7:0] p, input logic [7:0] c);
    case (p)
      8'h55:               step_legal = (c == 8'hAA) || (c == 8'h0F) || (c == 8'h00);
      8'hAA:               step_legal = (c == 8'hF0) || (c == 8'hFF);
      8'hF0:               step_legal = (c == 8'h55) || (c == 8'h00);
      8'h0F, 8'hFF, 8'h00: step_legal = (c == 8'h55);
      default:             step_legal = 1'b0;
    endcase
  endfunction

  state_t           r_state;
  logic [7:0]       r_prev;
  logic [3:0]       r_decoded;
  logic             r_state_valid;
  logic             r_violation;
  logic [7:0]       r_viol_prev;
  logic [7:0]       r_viol_cur;
  logic [CNT_W-1:0] r_err_count;
  logic             r_alarm;

  logic             w_stall;
  logic             w_legal;
  logic             w_viol;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_alarm_next;

`ifdef STATE_MON_STALL_EN
  assign w_stall = (code_in == r_prev);
`else
  assign w_stall = 1'b0;
`endif

  assign w_legal = code_known(code_in) && step_legal(r_prev, code_in);
  assign w_viol  = code_valid && (r_state == S_TRACK) && !w_stall && !w_legal;

  // Clear is applied before the increment, so a violation coinciding with
  // clr_alarm leaves the counter at exactly one.
  assign w_cnt_base   = clr_alarm ? '0 : r_err_count;
  assign w_cnt_next   = (w_viol && !(&w_cnt_base)) ? (w_cnt_base + CNT_W'(1)) : w_cnt_base;
  assign w_alarm_next = (clr_alarm ? 1'b0 : r_alarm) |
                        (w_viol && (w_cnt_next >= CNT_W'(ALARM_THRESH)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_UNSYNC;
      r_prev        <= c_SYNC_CODE;
      r_decoded     <= 4'h0;
      r_state_valid <= 1'b0;
      r_violation   <= 1'b0;
      r_viol_prev   <= 8'h00;
      r_viol_cur    <= 8'h00;
      r_err_count   <= '0;
      r_alarm       <= 1'b0;
    end else begin
      r_state_valid <= 1'b0;
      r_violation   <= 1'b0;
      r_err_count   <= w_cnt_next;
      r_alarm       <= w_alarm_next;
      if (code_valid) begin
        case (r_state)
          S_UNSYNC: begin
            // Anything but the sync code is silently ignored while unsynced.
            if (code_in == c_SYNC_CODE) begin
              r_prev  <= c_SYNC_CODE;
              r_state <= S_TRACK;
            end
          end
          S_TRACK: begin
            if (w_stall) begin
              r_state_valid <= 1'b1;
            end else if (w_legal) begin
              r_prev        <= code_in;
              r_decoded     <= code_index(code_in);
              r_state_valid <= 1'b1;
            end else begin
              r_violation <= 1'b1;
              r_viol_prev <= r_prev;
              r_viol_cur  <= code_in;
              r_state     <= S_UNSYNC;
            end
          end
          default: r_state <= S_UNSYNC;
        endcase
      end
    end
  end

  assign decoded_state = r_decoded;
  assign state_valid   = r_state_valid;
  assign synced        = (r_state == S_TRACK);
  assign violation     = r_violation;
  assign viol_prev     = r_viol_prev;
  assign viol_cur      = r_viol_cur;
  assign err_count     = r_err_count;
  assign alarm         = r_alarm;

endmodule
`default_nettype wire

// File: doc/state_code_monitor.md
# state_code_monitor

Passive checker that sits on the 8-bit state code bus driven by the control-state FSM.
- Decodes each sampled code back to the FSM state index.
- Checks every step against the legal transition set and counts violations.
- Raises a sticky alarm once a threshold is reached.
- Feeds the security status block; never drives the FSM.

## Interface
- ALARM_THRESH, default 4: violation count at which `alarm` asserts (1..2^CNT_W-1).
- CNT_W, default 4: width of the saturating violation counter.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- code_in  in  8  state code from FSM.
- code_valid  in  1  code_in sampled this cycle.
- clr_alarm  in  1  clear alarm and counter (level, sampled each cycle).
- decoded_state  out  4  last decoded state index.
- state_valid  out  1  pulse: decoded_state updated.
- synced  out  1  monitor tracking a known state.
- violation  out  1  pulse: illegal code or transition.
- viol_prev  out  8  previous code of the last violation.
- viol_cur  out  8  offending code of the last violation.
- err_count  out  CNT_W  saturating violation count.
- alarm  out  1  sticky, count >= ALARM_THRESH.

## Operation
- Code map:
  - 0x55 -> 0x0
  - 0xAA -> 0x1
  - 0xF0 -> 0x3
  - 0x0F -> 0xA
  - 0xFF -> 0xF
  - 0x00 -> 0x5 ("other"; covers FSM states 5/7)
  - Any other code is illegal.
- Legal successors (prev -> cur):
  - 0x55 -> {0xAA, 0x0F, 0x00}
  - 0xAA -> {0xF0, 0xFF}
  - 0xF0 -> {0x55, 0x00}
  - 0x0F, 0xFF, 0x00 -> {0x55}
- Monitor FSM states: UNSYNC, TRACK.
  - UNSYNC: the first valid 0x55 loads prev and moves to TRACK with `synced`=1. Other valid codes are ignored, with no violation.
  - TRACK, legal valid code: update prev and decoded_state, pulse `state_valid`.
  - TRACK, illegal code or illegal transition: pulse `violation`, capture viol_prev/viol_cur, increment err_count (saturate at all-ones), return to UNSYNC (`synced`=0). decoded_state holds.
- `alarm` sets when err_count >= ALARM_THRESH after the increment. It stays set until clr_alarm or reset.
- clr_alarm zeroes err_count and alarm, and does not affect sync state.
- Violation in the same cycle as clr_alarm: clear applies first, then the increment (err_count=1). `alarm` = (1 >= ALARM_THRESH).
- code_valid=0: no state change; pulses deassert.

## Timing
- All outputs are registered; latency is 1 cycle from the code_valid sample edge to state_valid/violation/err_count/alarm.
- Pulses last exactly one cycle. Back-to-back valid codes are accepted every cycle.
- Reset values:
  - decoded_state=0
  - state_valid=0
  - synced=0
  - violation=0
  - viol_prev=0x00
  - viol_cur=0x00
  - err_count=0
  - alarm=0
  - internal prev=0x55, FSM=UNSYNC
- Reset asserted mid-stream: all outputs return to reset values asynchronously. After release, the monitor needs a fresh 0x55 to resync.
- Counter saturation: at all-ones, further violations still pulse and capture, but the count holds.

## Configuration
- STATE_MON_STALL_EN:
  - Defined: in TRACK, a valid code equal to prev is a legal stall. It pulses `state_valid` and leaves decoded_state unchanged.
  - Undefined: a repeated code is an illegal transition and raises a violation.

## Test plan
- Reset, then valid stream 0x55, 0xAA, 0xF0, 0x55 -> synced=1 after the first code; decoded_state 0,1,3,0; no violation; err_count=0.
- In TRACK, send 0x55 then 0x12 -> violation pulse, viol_prev=0x55, viol_cur=0x12, err_count=1, synced=0. A following 0xAA is ignored; 0x55 resyncs.
- Four illegal transitions (0x55 -> 0xF0, each followed by a resync on 0x55) with ALARM_THRESH=4 -> alarm rises one cycle after the 4th violation and stays high across further legal traffic.
- clr_alarm in the same cycle as a violation -> err_count=1, alarm=0 (default threshold).
- 0x55, 0x55 in TRACK -> violation without STATE_MON_STALL_EN; state_valid with decoded_state=0 and no violation with it defined.
- Assert rst_n low mid-stream with err_count=3 -> all outputs zero immediately. After release, 0xAA is ignored and 0x55 resyncs.
